// File: rtl/common.sv
// Shared execute-stage types: datapath word, multiply/divide opcode and control word.
package common;

    typedef logic [63:0] word_t;

    typedef enum logic [2:0] {
        MUL  = 3'd0,
        DIV  = 3'd1,
        DIVU = 3'd2,
        REM  = 3'd3,
        REMU = 3'd4
    } mdu_op_t;

    typedef struct packed {
        logic aluEn;
        logic mdu;
        logic memRd;
        logic memWr;
        logic regWr;
    } exCtrl_t;

    function automatic word_t sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // W-variants produce a 32-bit result that is sign-extended into the full word.
    function automatic word_t fixWidth(input word_t v, input logic w);
        return w ? sext32(v[31:0]) : v;
    endfunction

    function automatic logic isSignedDiv(input mdu_op_t o);
        return (o == DIV) || (o == REM);
    endfunction

    function automatic logic isRem(input mdu_op_t o);
        return (o == REM) || (o == REMU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MSB-first shift-add multiplier or restoring divider.
module mdu_step #(
    parameter int XLEN = 64
) (
    input  logic            isDiv,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] sreg,
    input  logic [XLEN-1:0] other,
    output logic [XLEN-1:0] accNext,
    output logic [XLEN-1:0] sregNext
);

    logic [XLEN:0] remShift;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        remShift = {acc, sreg[XLEN-1]};
        diff     = remShift - {1'b0, other};
        fits     = ~diff[XLEN];
        accNext  = '0;
        sregNext = '0;
        if (isDiv) begin
            // Partial remainder stays below the divisor, so one extra bit covers the shift.
            accNext  = fits ? diff[XLEN-1:0] : remShift[XLEN-1:0];
            sregNext = {sreg[XLEN-2:0], fits};
        end else begin
            accNext  = {acc[XLEN-2:0], 1'b0} + (sreg[XLEN-1] ? other : '0);
            sregNext = {sreg[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer with valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for an operation
//   BUSY  | iterating, cnt counts down to the last step
//   DONE  | result held until the consumer takes it
module mdu_seq
    import common::*;
#(
    parameter int XLEN = 64
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    output logic    in_ready,
    input  mdu_op_t op,
    input  logic    word,
    input  word_t   src1,
    input  word_t   src2,
    input  logic    flush,
    output logic    out_valid,
    input  logic    out_ready,
    output word_t   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [5:0]      cnt;
    mdu_op_t         opReg;
    logic            wordReg, negQ, negR;
    logic [XLEN-1:0] acc, sreg, other, resultReg;
    logic [XLEN-1:0] accNext, sregNext;

    logic            accept, sgn, aNeg, bNeg, divZero, overflow, special;
    logic [XLEN-1:0] opA, opB, magA, magB, minVal, specialRes, mulInit, divInit;
    logic [XLEN-1:0] divQ, divR, finalRes;

    assign accept = in_valid && !flush;

    // Operand preparation and one-cycle special cases.
    always_comb begin
        sgn      = isSignedDiv(op);
        opA      = word ? (sgn ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
        opB      = word ? (sgn ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
        aNeg     = sgn && opA[XLEN-1];
        bNeg     = sgn && opB[XLEN-1];
        magA     = aNeg ? -opA : opA;
        magB     = bNeg ? -opB : opB;
        minVal   = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        divZero  = (op != MUL) && (opB == '0);
        overflow = sgn && (opA == minVal) && (opB == '1);
        special  = divZero || overflow;
        if (divZero)
            specialRes = fixWidth(isRem(op) ? opA : '1, word);
        else
            specialRes = fixWidth(isRem(op) ? '0 : opA, word);
        // Operands are aligned to the top so the step always consumes bit XLEN-1.
        mulInit  = word ? {src2[31:0], 32'b0} : src2;
        divInit  = word ? {magA[31:0], 32'b0} : magA;
    end

    mdu_step #(.XLEN(XLEN)) uStep (
        .isDiv    (opReg != MUL),
        .acc      (acc),
        .sreg     (sreg),
        .other    (other),
        .accNext  (accNext),
        .sregNext (sregNext)
    );

    always_comb begin
        divQ     = negQ ? -sregNext : sregNext;
        divR     = negR ? -accNext : accNext;
        finalRes = fixWidth((opReg == MUL) ? accNext : (isRem(opReg) ? divR : divQ), wordReg);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    stateNext = special ? DONE : BUSY;
            end
            BUSY: begin
                if (flush)
                    stateNext = IDLE;
                else if (cnt == 6'd0)
                    stateNext = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            opReg     <= MUL;
            wordReg   <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            acc       <= '0;
            sreg      <= '0;
            other     <= '0;
            resultReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg   <= op;
                        wordReg <= word;
                        negQ    <= aNeg ^ bNeg;
                        negR    <= aNeg;
                        acc     <= '0;
                        sreg    <= (op == MUL) ? mulInit : divInit;
                        other   <= (op == MUL) ? src1 : magB;
                        cnt     <= word ? 6'd31 : 6'd63;
                        if (special)
                            resultReg <= specialRes;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc  <= accNext;
                        sreg <= sregNext;
                        if (cnt == 6'd0)
                            resultReg <= finalRes;
                        else
                            cnt <= cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = resultReg;

endmodule
